// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: aligns, issues and times out MEM-stage loads/stores on a
// request/ack data bus, stalling the pipeline until the access completes.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_dmen,
  input  logic        mem_memwr,
  input  logic [1:0]  mem_dm_type,
  input  logic        mem_dm_extsigned,
  input  logic [31:0] mem_result,
  input  logic [31:0] mem_rt,
  input  logic        flush_i,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        align_err_o,
  output logic        bus_err_o
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [31:0] ldata_q, ldata_d;
  logic        err_q, err_d;

  logic        misaligned, req_valid, start, timeout_hit;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc, load_fmt;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign misaligned  = ((mem_dm_type == 2'b01) && mem_result[0]) ||
                       (mem_dm_type[1] && (mem_result[1:0] != 2'b00));
  assign req_valid   = mem_dmen && !flush_i;
  assign start       = req_valid && !misaligned;
  assign timeout_hit = (cnt_q == TimeoutLast);

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = mem_rt;
    unique case (mem_dm_type)
      2'b00: begin
        be_calc    = 4'b0001 << mem_result[1:0];
        wdata_calc = {4{mem_rt[7:0]}};
      end
      2'b01: begin
        be_calc    = mem_result[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{mem_rt[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select uses the byte offset captured at request time.
  always_comb begin
    unique case (lane_q)
      2'b00:   byte_sel = dbus_rdata[7:0];
      2'b01:   byte_sel = dbus_rdata[15:8];
      2'b10:   byte_sel = dbus_rdata[23:16];
      default: byte_sel = dbus_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    unique case (size_q)
      2'b00:   load_fmt = {{24{sext_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_fmt = {{16{sext_q & half_sel[15]}}, half_sel};
      default: load_fmt = dbus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StBusy;
      StBusy:  if (dbus_ack || timeout_hit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dbus_req     = (state_q == StBusy);
    stall_o      = reset && (((state_q == StIdle) && start) || (state_q == StBusy));
    align_err_o  = (state_q == StIdle) && req_valid && misaligned;
    load_valid_o = (state_q == StDone) && !we_q;
  end

  always_comb begin
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    lane_d  = lane_q;
    size_d  = size_q;
    sext_d  = sext_q;
    ldata_d = ldata_q;
    err_d   = 1'b0;
    if ((state_q == StIdle) && start) begin
      cnt_d   = 8'd0;
      we_d    = mem_memwr;
      addr_d  = {mem_result[31:2], 2'b00};
      be_d    = be_calc;
      wdata_d = wdata_calc;
      lane_d  = mem_result[1:0];
      size_d  = mem_dm_type;
      sext_d  = mem_dm_extsigned;
    end
    // Ack takes priority over a timeout landing in the same cycle.
    if (state_q == StBusy) begin
      if (dbus_ack) begin
        if (!we_q) ldata_d = load_fmt;
      end else if (timeout_hit) begin
        ldata_d = 32'd0;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      lane_q  <= 2'd0;
      size_q  <= 2'd0;
      sext_q  <= 1'b0;
      ldata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      ldata_q <= ldata_d;
      err_q   <= err_d;
    end
  end

  assign dbus_we     = we_q;
  assign dbus_addr   = addr_q;
  assign dbus_be     = be_q;
  assign dbus_wdata  = wdata_q;
  assign load_data_o = ldata_q;
  assign bus_err_o   = err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: fixed vectors, directed corner sequences and random accesses
// compared against a byte-level reference model.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_dmen, mem_memwr, mem_dm_extsigned, flush_i, dbus_ack;
  logic [1:0]  mem_dm_type;
  logic [31:0] mem_result, mem_rt, dbus_rdata;
  logic        dbus_req, dbus_we, stall_o, load_valid_o, align_err_o, bus_err_o;
  logic [31:0] dbus_addr, dbus_wdata, load_data_o;
  logic [3:0]  dbus_be;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] last_load = 32'd0;

  dmem_access_ctrl #(.TIMEOUT(255)) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_dmen         (mem_dmen),
    .mem_memwr        (mem_memwr),
    .mem_dm_type      (mem_dm_type),
    .mem_dm_extsigned (mem_dm_extsigned),
    .mem_result       (mem_result),
    .mem_rt           (mem_rt),
    .flush_i          (flush_i),
    .dbus_ack         (dbus_ack),
    .dbus_rdata       (dbus_rdata),
    .dbus_req         (dbus_req),
    .dbus_we          (dbus_we),
    .dbus_addr        (dbus_addr),
    .dbus_be          (dbus_be),
    .dbus_wdata       (dbus_wdata),
    .stall_o          (stall_o),
    .load_data_o      (load_data_o),
    .load_valid_o     (load_valid_o),
    .align_err_o      (align_err_o),
    .bus_err_o        (bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference model: accesses as byte counts and byte offsets.
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
    int n   = nbytes(size);
    int off = (n == 4) ? 0 : int'(addr % 4);
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] rt);
    logic [31:0] r;
    int n = nbytes(size);
    for (int j = 0; j < 4; j++) r[8*j +: 8] = rt[8*(j % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic sext,
                                         input logic [31:0] addr, input logic [31:0] rdata);
    logic [63:0] v, mask;
    int n   = nbytes(size);
    int off = (n == 4) ? 0 : int'(addr % 4);
    v    = {32'd0, rdata} >> (8 * off);
    mask = (64'd1 << (8 * n)) - 64'd1;
    v    = v & mask;
    if (sext && n < 4 && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic idle_inputs();
    mem_dmen = 1'b0; mem_memwr = 1'b0; mem_dm_type = 2'b00; mem_dm_extsigned = 1'b0;
    mem_result = 32'd0; mem_rt = 32'd0; flush_i = 1'b0; dbus_ack = 1'b0; dbus_rdata = 32'd0;
  endtask

  // One complete access; ack arrives in BUSY cycle number `delay` (0-based).
  task automatic do_access(input string tag, input logic we, input logic [1:0] size,
                           input logic sext, input logic [31:0] addr, input logic [31:0] rt,
                           input logic [31:0] rdata, input int delay, input bit flush_busy,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_load);
    int stalls = 0;
    @(negedge clk);
    mem_dmen = 1'b1; mem_memwr = we; mem_dm_type = size; mem_dm_extsigned = sext;
    mem_result = addr; mem_rt = rt; flush_i = 1'b0; dbus_ack = 1'b0; dbus_rdata = rdata;
    #1;
    chk({tag, " start stall"}, 32'(stall_o), 32'd1);
    chk({tag, " start align"}, 32'(align_err_o), 32'd0);
    chk({tag, " start req"}, 32'(dbus_req), 32'd0);
    if (stall_o) stalls++;
    for (int k = 0; k <= delay; k++) begin
      @(negedge clk);
      if (stall_o) stalls++;
      if (k == 0 || k == delay) begin
        chk({tag, " busy req"}, 32'(dbus_req), 32'd1);
        chk({tag, " addr"}, dbus_addr, exp_addr);
        chk({tag, " be"}, 32'(dbus_be), 32'(exp_be));
        chk({tag, " we"}, 32'(dbus_we), 32'(we));
        if (we) chk({tag, " wdata"}, dbus_wdata, exp_wdata);
      end
      flush_i  = flush_busy;
      dbus_ack = (k == delay);
    end
    @(negedge clk);
    if (!we) last_load = exp_load;
    chk({tag, " done stall"}, 32'(stall_o), 32'd0);
    chk({tag, " done req"}, 32'(dbus_req), 32'd0);
    chk({tag, " done lvalid"}, 32'(load_valid_o), 32'(!we));
    chk({tag, " done buserr"}, 32'(bus_err_o), 32'd0);
    chk({tag, " load data"}, load_data_o, last_load);
    chk({tag, " stall cycles"}, 32'(stalls), 32'(delay + 2));
    idle_inputs();
    @(negedge clk);
    chk({tag, " idle lvalid"}, 32'(load_valid_o), 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr, rt, rdata;
    int          delay;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_load;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [1:0]  sz;
    logic [31:0] a, rt, rd;
    logic        we, sx;
    int          busy;

    vecs[0] = '{1'b0, 2'b00, 1'b1, 32'h1003, 32'h0, 32'h80FF_FF00, 1,
                32'h1000, 4'b1000, 32'h0, 32'hFFFF_FF80};
    vecs[1] = '{1'b1, 2'b01, 1'b0, 32'h2002, 32'h1234_ABCD, 32'h0, 0,
                32'h2000, 4'b1100, 32'hABCD_ABCD, 32'h0};
    vecs[2] = '{1'b0, 2'b01, 1'b0, 32'h0010, 32'h0, 32'hDEAD_8001, 0,
                32'h0010, 4'b0011, 32'h0, 32'h0000_8001};
    vecs[3] = '{1'b0, 2'b01, 1'b1, 32'h0012, 32'h0, 32'hDEAD_8001, 2,
                32'h0010, 4'b1100, 32'h0, 32'hFFFF_DEAD};
    vecs[4] = '{1'b0, 2'b00, 1'b0, 32'h0021, 32'h0, 32'h1234_5678, 0,
                32'h0020, 4'b0010, 32'h0, 32'h0000_0056};
    vecs[5] = '{1'b0, 2'b10, 1'b1, 32'h0030, 32'h0, 32'h89AB_CDEF, 3,
                32'h0030, 4'b1111, 32'h0, 32'h89AB_CDEF};
    vecs[6] = '{1'b1, 2'b00, 1'b0, 32'h0042, 32'hFFFF_FF5A, 32'h0, 1,
                32'h0040, 4'b0100, 32'h5A5A_5A5A, 32'h0};
    vecs[7] = '{1'b1, 2'b10, 1'b0, 32'h0054, 32'hCAFE_F00D, 32'h0, 0,
                32'h0054, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[8] = '{1'b0, 2'b00, 1'b1, 32'h0060, 32'h0, 32'h0000_007F, 0,
                32'h0060, 4'b0001, 32'h0, 32'h0000_007F};
    vecs[9] = '{1'b0, 2'b11, 1'b0, 32'h0074, 32'h0, 32'h1122_3344, 0,
                32'h0074, 4'b1111, 32'h0, 32'h1122_3344};

    idle_inputs();
    reset = 1'b0;
    #3;
    chk("reset req", 32'(dbus_req), 32'd0);
    chk("reset stall", 32'(stall_o), 32'd0);
    chk("reset ldata", load_data_o, 32'd0);
    chk("reset buserr", 32'(bus_err_o), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i])
      do_access($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].sext, vecs[i].addr,
                vecs[i].rt, vecs[i].rdata, vecs[i].delay, 1'b0, vecs[i].exp_addr,
                vecs[i].exp_be, vecs[i].exp_wdata, vecs[i].exp_load);

    // Misaligned word: error flag, no request, no stall.
    @(negedge clk);
    mem_dmen = 1'b1; mem_dm_type = 2'b10; mem_result = 32'h0000_0006;
    #1;
    chk("misalign err", 32'(align_err_o), 32'd1);
    chk("misalign stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    chk("misalign req", 32'(dbus_req), 32'd0);
    flush_i = 1'b1;
    #1;
    chk("misalign flushed err", 32'(align_err_o), 32'd0);
    idle_inputs();

    // Flushed request in IDLE must not start.
    @(negedge clk);
    mem_dmen = 1'b1; mem_dm_type = 2'b10; mem_result = 32'h0000_0100; flush_i = 1'b1;
    #1;
    chk("flush idle stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    chk("flush idle req", 32'(dbus_req), 32'd0);
    idle_inputs();

    // Ack outside BUSY is ignored.
    @(negedge clk);
    dbus_ack = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("stray ack req", 32'(dbus_req), 32'd0);
    chk("stray ack lvalid", 32'(load_valid_o), 32'd0);
    chk("stray ack ldata", load_data_o, last_load);
    idle_inputs();

    // flush_i during BUSY does not cancel.
    do_access("flush busy", 1'b0, 2'b00, 1'b0, 32'h0000_0502, 32'h0, 32'h00C3_0000, 2, 1'b1,
              32'h0000_0500, 4'b0100, 32'h0, 32'h0000_00C3);

    // Ack in the last allowed BUSY cycle wins over timeout.
    do_access("ack at limit", 1'b0, 2'b10, 1'b0, 32'h0000_0700, 32'h0, 32'h5555_AAAA, 254,
              1'b0, 32'h0000_0700, 4'b1111, 32'h0, 32'h5555_AAAA);

    // Timeout: no ack ever.
    @(negedge clk);
    mem_dmen = 1'b1; mem_dm_type = 2'b10; mem_result = 32'h0000_0200;
    busy = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (dbus_req) busy++;
      else break;
    end
    last_load = 32'd0;
    chk("timeout busy cycles", 32'(busy), 32'd255);
    chk("timeout buserr", 32'(bus_err_o), 32'd1);
    chk("timeout ldata", load_data_o, 32'd0);
    chk("timeout lvalid", 32'(load_valid_o), 32'd1);
    chk("timeout stall", 32'(stall_o), 32'd0);
    idle_inputs();
    @(negedge clk);
    chk("timeout pulse end", 32'(bus_err_o), 32'd0);
    chk("timeout idle req", 32'(dbus_req), 32'd0);

    // Reset in the middle of BUSY.
    do_access("pre reset", 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 32'hA5A5_0F0F, 0, 1'b0,
              32'h0000_0300, 4'b1111, 32'h0, 32'hA5A5_0F0F);
    @(negedge clk);
    mem_dmen = 1'b1; mem_memwr = 1'b1; mem_dm_type = 2'b10; mem_result = 32'h0000_0400;
    mem_rt = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("pre reset busy", 32'(dbus_req), 32'd1);
    reset = 1'b0;
    #1;
    last_load = 32'd0;
    chk("rst req", 32'(dbus_req), 32'd0);
    chk("rst we", 32'(dbus_we), 32'd0);
    chk("rst addr", dbus_addr, 32'd0);
    chk("rst be", 32'(dbus_be), 32'd0);
    chk("rst wdata", dbus_wdata, 32'd0);
    chk("rst ldata", load_data_o, 32'd0);
    chk("rst lvalid", 32'(load_valid_o), 32'd0);
    chk("rst buserr", 32'(bus_err_o), 32'd0);
    chk("rst stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post rst start stall", 32'(stall_o), 32'd1);
    chk("post rst req", 32'(dbus_req), 32'd0);
    chk("post rst buserr", 32'(bus_err_o), 32'd0);
    idle_inputs();
    @(negedge clk);

    // Random aligned and misaligned traffic against the model.
    for (int t = 0; t < 150; t++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      rt = $urandom;
      rd = $urandom;
      we = 1'($urandom_range(0, 1));
      sx = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0 && sz != 2'b00) begin
        if (sz == 2'b01) a[0] = 1'b1;
        else if (a[1:0] == 2'b00) a[1] = 1'b1;
        @(negedge clk);
        mem_dmen = 1'b1; mem_dm_type = sz; mem_result = a; mem_memwr = we;
        #1;
        chk("rand misalign err", 32'(align_err_o), 32'd1);
        chk("rand misalign stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        chk("rand misalign req", 32'(dbus_req), 32'd0);
        idle_inputs();
      end else begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz[1]) a[1:0] = 2'b00;
        do_access("rand", we, sz, sx, a, rt, rd, int'($urandom_range(0, 4)),
                  1'($urandom_range(0, 1)), {a[31:2], 2'b00}, m_be(sz, a), m_wdata(sz, rt),
                  m_load(sz, sx, a, rd));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports clk and reset.
REQ-002 The ports SHALL be, one per line (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- mem_dmen  in  1  MEM-stage instruction accesses data memory
- mem_memwr  in  1  1 = store, 0 = load
- mem_dm_type  in  2  access size: 00 byte, 01 half, 10 or 11 word
- mem_dm_extsigned  in  1  sign-extend loads
- mem_result  in  32  byte address
- mem_rt  in  32  store data
- flush_i  in  1  MEM-stage instruction is cancelled
- dbus_ack  in  1  bus transfer complete
- dbus_rdata  in  32  bus read data
- dbus_req  out  1  bus request
- dbus_we  out  1  bus write enable
- dbus_addr  out  32  word address, bits [1:0] = 00
- dbus_be  out  4  byte enables
- dbus_wdata  out  32  lane-replicated store data
- stall_o  out  1  hold the pipeline; drives EX/MEM pa_idexmemwr
- load_data_o  out  32  formatted load result
- load_valid_o  out  1  load_data_o is valid this cycle
- align_err_o  out  1  misaligned access, combinational
- bus_err_o  out  1  bus timeout pulse
REQ-003 The block SHALL have one parameter: TIMEOUT, default 255, giving the number of BUSY cycles allowed before abort.

Function
REQ-004 The FSM SHALL have three states, IDLE, BUSY and DONE, with a registered state.
REQ-005 Misalignment SHALL be defined as:
- half access with addr[0] = 1
- word access with addr[1:0] != 00
REQ-006 In IDLE, align_err_o SHALL equal mem_dmen & !flush_i & misaligned; when it is asserted, the block SHALL issue no request and SHALL NOT stall.
REQ-007 In IDLE, an aligned mem_dmen & !flush_i (called "start") SHALL cause all of the following:
- stall_o = 1 combinationally
- register dbus_we, dbus_addr, dbus_be and dbus_wdata
- move to BUSY
REQ-008 In BUSY, dbus_req and stall_o SHALL be 1, and the bus outputs SHALL stay stable until ack or timeout.
REQ-009 On dbus_ack in BUSY, the block SHALL:
- register the formatted dbus_rdata into load_data_o (loads only)
- move to DONE
REQ-010 In DONE, the block SHALL:
- drive stall_o = 0 and dbus_req = 0
- drive load_valid_o = 1 for a load
- return to IDLE on the next edge
REQ-011 The minimum access time SHALL be 3 cycles (IDLE, BUSY, DONE), with ack in the first BUSY cycle.
REQ-012 An 8-bit cycle counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack; when it reaches TIMEOUT, the block SHALL:
- pulse bus_err_o for one cycle
- set load_data_o to 0
- move to DONE
REQ-013 Ack arriving in the same cycle the counter reaches TIMEOUT SHALL win: completion is normal and bus_err_o stays 0.
REQ-014 flush_i SHALL be honoured only in IDLE; once in BUSY, the bus transaction SHALL complete and flush_i SHALL be ignored until IDLE.
REQ-015 Byte enables (lane = addr[1:0]) SHALL be:
- byte: 0001 << lane
- half: 0011 if addr[1] = 0, else 1100
- word: 1111
REQ-016 Store data SHALL be replicated across lanes:
- byte: {4{rt[7:0]}}
- half: {2{rt[15:0]}}
- word: rt
REQ-017 Load data SHALL be selected from the addressed lane and zero- or sign-extended to 32 bits according to mem_dm_extsigned; word loads SHALL pass through unchanged.
REQ-018 dbus_ack received outside BUSY SHALL be ignored.

Reset
REQ-019 When reset = 0, the block SHALL immediately:
- set state to IDLE and counter to 0
- drive all outputs to 0 (dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, load_data_o, load_valid_o, bus_err_o, stall_o)
REQ-020 Reset asserted mid-BUSY SHALL abandon the transaction with no error pulse; the first evaluation after release SHALL occur in IDLE.

Verification
REQ-021 Signed byte load: addr 0x1003, type 00, extsigned 1, rdata 0x80FF_FF00, ack after 2 BUSY cycles -> stall_o high for 3 cycles, dbus_be 0000? no: dbus_be = 1000, load_data_o = 0xFFFF_FF80 with load_valid_o for 1 cycle.
REQ-022 Half store: addr 0x2002, rt 0x1234_ABCD -> dbus_we = 1, dbus_be = 1100, dbus_wdata = 0xABCD_ABCD, dbus_addr = 0x2000.
REQ-023 Misaligned word: addr 0x0000_0006, type 10 -> align_err_o = 1, dbus_req never asserts, stall_o = 0.
REQ-024 Timeout: word load, dbus_ack never asserted -> bus_err_o pulses after 255 BUSY cycles, load_data_o = 0, state returns to IDLE.
REQ-025 Reset mid-BUSY, and flush_i asserted in BUSY -> on reset, all outputs 0 immediately; under flush_i, the transaction still completes on ack.
